// File: rtl/adc_seq.sv
// adc_seq: ADC channel sequencer for the real-time-status stage.
//
// Round-robins through up to six analog channels (0 pvin, 1 iout1, 2 iout2,
// 3 vout, 4 temp, 5 vcc). For each channel it drives the analog mux, waits
// SETTLE cycles, fires one adc_start pulse and then waits for adc_done. The
// result goes out as a single-cycle wr_len / wr_wdata / wr_chan write strobe.
//
// Optional feature: define ADC_SEQ_TIMEOUT_EN to compile in the conversion
// timeout. With it, a conversion not completed within TIMEOUT cycles after
// adc_start sets the sticky seq_err and skips the write. Without it, CONVERT
// waits indefinitely and seq_err stays 0.
//
// Ports:
//   wr_clk      in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   enable      in   run sequencer
//   chan_mask   in   [5:0] per-channel enable
//   err_clr     in   clears sticky seq_err
//   adc_done    in   conversion-complete pulse
//   adc_result  in   [IWIDTH-1:0] result, valid with adc_done
//   adc_mux     out  [2:0] analog mux select (current channel)
//   adc_start   out  one-cycle conversion start
//   wr_len      out  one-cycle result write strobe
//   wr_wdata    out  [IWIDTH-1:0] captured result
//   wr_chan     out  [2:0] channel of wr_wdata
//   frame_done  out  one-cycle pulse after the last enabled channel of a round
//   seq_err     out  sticky conversion-timeout flag
module adc_seq #(
  parameter int IWIDTH  = 10,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [5:0]        chan_mask,
  input  logic              err_clr,
  input  logic              adc_done,
  input  logic [IWIDTH-1:0] adc_result,
  output logic [2:0]        adc_mux,
  output logic              adc_start,
  output logic              wr_len,
  output logic [IWIDTH-1:0] wr_wdata,
  output logic [2:0]        wr_chan,
  output logic              frame_done,
  output logic              seq_err
);

  // One counter serves both the settle wait and the conversion timeout.
  localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SELECT, CONVERT, WRITE, NEXT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        chan_d;
  logic              start_d;
  logic              wlen_d;
  logic              fdone_d;
  logic              err_set;
  logic [IWIDTH-1:0] wdata_d;
  logic [2:0]        wchan_d;
  logic [3:0]        nxt;
  logic              frame_wrap;

  function automatic logic [2:0] first_chan(input logic [5:0] mask);
    first_chan = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (mask[i]) first_chan = 3'(i);
    end
  endfunction

  // Returns {wrapped, channel}: next set bit above cur, modulo 6. A search
  // that lands at or below cur (single-channel mask included) has wrapped.
  function automatic logic [3:0] next_chan(input logic [5:0] mask, input logic [2:0] cur);
    logic [2:0] idx;
    logic       found;
    next_chan = {1'b1, cur};
    found     = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      idx = 3'((int'(cur) + i) % 6);
      if (!found && mask[idx]) begin
        found     = 1'b1;
        next_chan = {(idx <= cur), idx};
      end
    end
  endfunction

  assign nxt = next_chan(chan_mask, adc_mux);

  // frame_done is registered, so the wrap decision is looked ahead on the
  // transition into NEXT; it is suppressed when NEXT is going to stop.
  assign frame_wrap = enable && (chan_mask != 6'd0) && nxt[3];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = adc_mux;
    start_d = 1'b0;
    wlen_d  = 1'b0;
    fdone_d = 1'b0;
    err_set = 1'b0;
    wdata_d = wr_wdata;
    wchan_d = wr_chan;
    case (state_q)
      IDLE: begin
        if (enable && (chan_mask != 6'd0)) begin
          chan_d  = first_chan(chan_mask);
          cnt_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = CONVERT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONVERT: begin
        // adc_start is high only in the first CONVERT cycle, so it doubles
        // as the "ignore adc_done now" qualifier.
        if (!adc_start && adc_done) begin
          wdata_d = adc_result;
          wchan_d = adc_mux;
          wlen_d  = 1'b1;
          cnt_d   = '0;
          state_d = WRITE;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_set = 1'b1;
          fdone_d = frame_wrap;
          cnt_d   = '0;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      WRITE: begin
        fdone_d = frame_wrap;
        state_d = NEXT;
      end
      NEXT: begin
        if (!enable || (chan_mask == 6'd0)) begin
          state_d = IDLE;
        end else begin
          chan_d  = nxt[2:0];
          cnt_d   = '0;
          state_d = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      adc_mux    <= 3'd0;
      adc_start  <= 1'b0;
      wr_len     <= 1'b0;
      wr_wdata   <= '0;
      wr_chan    <= 3'd0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adc_mux    <= chan_d;
      adc_start  <= start_d;
      wr_len     <= wlen_d;
      wr_wdata   <= wdata_d;
      wr_chan    <= wchan_d;
      frame_done <= fdone_d;
      // A new timeout beats a simultaneous clear.
      seq_err    <= err_set | (seq_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_adc_seq.sv
// tb_adc_seq: directed bench for adc_seq (IWIDTH=10, SETTLE=4, TIMEOUT=8).
// An ADC responder process answers adc_start according to adc_mode; a
// monitor logs write strobes, frame_done and adc_start with cycle numbers.
module tb_adc_seq;

  localparam int IW = 10;

  logic          wr_clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [5:0]    chan_mask;
  logic          err_clr;
  logic          adc_done;
  logic [IW-1:0] adc_result;
  logic [2:0]    adc_mux;
  logic          adc_start;
  logic          wr_len;
  logic [IW-1:0] wr_wdata;
  logic [2:0]    wr_chan;
  logic          frame_done;
  logic          seq_err;

  int cmp_cnt  = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  // 0 silent, 1 done 3 cycles after start, 2 early pulse then 3FF at +2,
  // 3 like 1 but channel 2 never answers
  int adc_mode = 0;

  int            wr_cyc_q[$];
  logic [2:0]    wr_chan_q[$];
  logic [IW-1:0] wr_data_q[$];
  int            fd_cyc_q[$];
  int            st_cyc_q[$];
  logic [2:0]    adc_ch;

  adc_seq #(.IWIDTH(IW), .SETTLE(4), .TIMEOUT(8)) dut (
    .wr_clk(wr_clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
    .err_clr(err_clr), .adc_done(adc_done), .adc_result(adc_result),
    .adc_mux(adc_mux), .adc_start(adc_start), .wr_len(wr_len),
    .wr_wdata(wr_wdata), .wr_chan(wr_chan), .frame_done(frame_done),
    .seq_err(seq_err)
  );

  always #5 wr_clk = ~wr_clk;

  // cyc = k during the cycle that follows the k-th rising edge.
  always @(posedge wr_clk) cyc <= cyc + 1;

  initial begin
    adc_done   = 1'b0;
    adc_result = '0;
    forever begin
      @(posedge wr_clk); #1;
      adc_done = 1'b0;
      if (adc_start === 1'b1 && adc_mode != 0) begin
        adc_ch = adc_mux;
        if (adc_mode == 2) begin
          adc_done = 1'b1; adc_result = 10'h0AA;
          @(posedge wr_clk); #1;
          adc_done = 1'b0;
          @(posedge wr_clk); #1;
          adc_done = 1'b1; adc_result = 10'h3FF;
        end else if (!(adc_mode == 3 && adc_ch == 3'd2)) begin
          repeat (3) begin @(posedge wr_clk); #1; end
          adc_done = 1'b1; adc_result = 10'h155 + IW'(adc_ch);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge wr_clk); #2;
      if (wr_len === 1'b1) begin
        wr_cyc_q.push_back(cyc); wr_chan_q.push_back(wr_chan); wr_data_q.push_back(wr_wdata);
      end
      if (frame_done === 1'b1) fd_cyc_q.push_back(cyc);
      if (adc_start === 1'b1) st_cyc_q.push_back(cyc);
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge wr_clk); #1; end
  endtask

  task automatic do_reset();
    enable = 1'b0; adc_mode = 0; err_clr = 1'b0; chan_mask = 6'd0;
    reset = 1'b1;
    repeat (2) @(posedge wr_clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; chan_mask = 6'd0; err_clr = 1'b0;
    repeat (2) @(posedge wr_clk); #1;
    cmp_cnt++; if (adc_mux !== 3'd0)    begin err_cnt++; $display("FAIL reset_adc_mux: got %0d expected 0", adc_mux); end
    cmp_cnt++; if (adc_start !== 1'b0)  begin err_cnt++; $display("FAIL reset_adc_start: got %b expected 0", adc_start); end
    cmp_cnt++; if (wr_len !== 1'b0)     begin err_cnt++; $display("FAIL reset_wr_len: got %b expected 0", wr_len); end
    cmp_cnt++; if (wr_wdata !== 10'h0)  begin err_cnt++; $display("FAIL reset_wr_wdata: got %h expected 000", wr_wdata); end
    cmp_cnt++; if (wr_chan !== 3'd0)    begin err_cnt++; $display("FAIL reset_wr_chan: got %0d expected 0", wr_chan); end
    cmp_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    cmp_cnt++; if (seq_err !== 1'b0)    begin err_cnt++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
    reset = 1'b0;
  endtask

  task automatic test_full_round();
    int k0, wb, fb, sb, a_c, a_f;
    logic [2:0] a_ch;
    logic [IW-1:0] a_d;
    do_reset();
    wb = wr_cyc_q.size(); fb = fd_cyc_q.size(); sb = st_cyc_q.size();
    adc_mode = 1; chan_mask = 6'h3F; enable = 1'b1; k0 = cyc;
    wait_cyc(k0 + 62);
    a_c = (st_cyc_q.size() > sb) ? st_cyc_q[sb] : -1;
    cmp_cnt++; if (a_c != k0 + 5) begin err_cnt++; $display("FAIL full_first_start_cycle: got %0d expected %0d", a_c - k0, 5); end
    cmp_cnt++; if (wr_cyc_q.size() - wb != 6) begin err_cnt++; $display("FAIL full_write_count: got %0d expected 6", wr_cyc_q.size() - wb); end
    for (int n = 0; n < 6; n++) begin
      if (wr_cyc_q.size() > wb + n) begin
        a_c = wr_cyc_q[wb + n]; a_ch = wr_chan_q[wb + n]; a_d = wr_data_q[wb + n];
      end else begin
        a_c = -1; a_ch = 3'd7; a_d = 10'h000;
      end
      cmp_cnt++; if (a_c != k0 + 9 + 10 * n) begin err_cnt++; $display("FAIL full_write%0d_cycle: got %0d expected %0d", n, a_c - k0, 9 + 10 * n); end
      cmp_cnt++; if (a_ch !== 3'(n)) begin err_cnt++; $display("FAIL full_write%0d_chan: got %0d expected %0d", n, a_ch, n); end
      cmp_cnt++; if (a_d !== 10'h155 + 10'(n)) begin err_cnt++; $display("FAIL full_write%0d_data: got %h expected %h", n, a_d, 10'h155 + 10'(n)); end
    end
    cmp_cnt++; if (fd_cyc_q.size() - fb != 1) begin err_cnt++; $display("FAIL full_frame_count: got %0d expected 1", fd_cyc_q.size() - fb); end
    a_f = (fd_cyc_q.size() > fb) ? fd_cyc_q[fb] : -1;
    cmp_cnt++; if (a_f != k0 + 60) begin err_cnt++; $display("FAIL full_frame_cycle: got %0d expected 60", a_f - k0); end
  endtask

  task automatic test_sparse();
    int k0, wb, fb, a_c, a_f;
    logic [2:0] a_ch;
    logic [2:0] exp_ch [4];
    exp_ch = '{3'd1, 3'd4, 3'd1, 3'd4};
    do_reset();
    wb = wr_cyc_q.size(); fb = fd_cyc_q.size();
    adc_mode = 1; chan_mask = 6'b010010; enable = 1'b1; k0 = cyc;
    for (int c = 1; c <= 40; c++) begin
      wait_cyc(k0 + c);
      cmp_cnt++; if (adc_mux !== 3'd1 && adc_mux !== 3'd4) begin err_cnt++; $display("FAIL sparse_mux_c%0d: got %0d expected 1 or 4", c, adc_mux); end
    end
    wait_cyc(k0 + 42);
    cmp_cnt++; if (wr_cyc_q.size() - wb != 4) begin err_cnt++; $display("FAIL sparse_write_count: got %0d expected 4", wr_cyc_q.size() - wb); end
    for (int n = 0; n < 4; n++) begin
      if (wr_cyc_q.size() > wb + n) begin a_c = wr_cyc_q[wb + n]; a_ch = wr_chan_q[wb + n]; end
      else begin a_c = -1; a_ch = 3'd7; end
      cmp_cnt++; if (a_ch !== exp_ch[n]) begin err_cnt++; $display("FAIL sparse_write%0d_chan: got %0d expected %0d", n, a_ch, exp_ch[n]); end
      cmp_cnt++; if (a_c != k0 + 9 + 10 * n) begin err_cnt++; $display("FAIL sparse_write%0d_cycle: got %0d expected %0d", n, a_c - k0, 9 + 10 * n); end
    end
    cmp_cnt++; if (fd_cyc_q.size() - fb != 2) begin err_cnt++; $display("FAIL sparse_frame_count: got %0d expected 2", fd_cyc_q.size() - fb); end
    for (int n = 0; n < 2; n++) begin
      a_f = (fd_cyc_q.size() > fb + n) ? fd_cyc_q[fb + n] : -1;
      cmp_cnt++; if (a_f != k0 + 20 + 20 * n) begin err_cnt++; $display("FAIL sparse_frame%0d_cycle: got %0d expected %0d", n, a_f - k0, 20 + 20 * n); end
    end
  endtask

  task automatic test_early_done();
    int k0, wb;
    do_reset();
    wb = wr_cyc_q.size();
    adc_mode = 2; chan_mask = 6'b000001; enable = 1'b1; k0 = cyc;
    wait_cyc(k0 + 8);
    cmp_cnt++; if (wr_len !== 1'b1) begin err_cnt++; $display("FAIL early_wr_len: got %b expected 1", wr_len); end
    cmp_cnt++; if (wr_wdata !== 10'h3FF) begin err_cnt++; $display("FAIL early_wr_wdata: got %h expected 3ff", wr_wdata); end
    cmp_cnt++; if (wr_chan !== 3'd0) begin err_cnt++; $display("FAIL early_wr_chan: got %0d expected 0", wr_chan); end
    wait_cyc(k0 + 9);
    cmp_cnt++; if (frame_done !== 1'b1) begin err_cnt++; $display("FAIL early_single_frame_done: got %b expected 1", frame_done); end
    cmp_cnt++; if (wr_len !== 1'b0) begin err_cnt++; $display("FAIL early_wr_len_single: got %b expected 0", wr_len); end
    wait_cyc(k0 + 15);
    cmp_cnt++; if (wr_wdata !== 10'h3FF) begin err_cnt++; $display("FAIL early_wdata_hold: got %h expected 3ff", wr_wdata); end
    cmp_cnt++; if (wr_cyc_q.size() - wb != 1) begin err_cnt++; $display("FAIL early_write_count: got %0d expected 1", wr_cyc_q.size() - wb); end
  endtask

  task automatic test_enable_drop();
    int k0, wb, fb, sb, a_c;
    logic [2:0] a_ch;
    do_reset();
    wb = wr_cyc_q.size(); fb = fd_cyc_q.size(); sb = st_cyc_q.size();
    adc_mode = 1; chan_mask = 6'h3F; enable = 1'b1; k0 = cyc;
    wait_cyc(k0 + 36);
    enable = 1'b0;
    wait_cyc(k0 + 70);
    cmp_cnt++; if (wr_cyc_q.size() - wb != 4) begin err_cnt++; $display("FAIL drop_write_count: got %0d expected 4", wr_cyc_q.size() - wb); end
    if (wr_cyc_q.size() > wb + 3) begin a_c = wr_cyc_q[wb + 3]; a_ch = wr_chan_q[wb + 3]; end
    else begin a_c = -1; a_ch = 3'd7; end
    cmp_cnt++; if (a_ch !== 3'd3) begin err_cnt++; $display("FAIL drop_last_chan: got %0d expected 3", a_ch); end
    cmp_cnt++; if (a_c != k0 + 39) begin err_cnt++; $display("FAIL drop_last_cycle: got %0d expected 39", a_c - k0); end
    cmp_cnt++; if (st_cyc_q.size() - sb != 4) begin err_cnt++; $display("FAIL drop_start_count: got %0d expected 4", st_cyc_q.size() - sb); end
    cmp_cnt++; if (fd_cyc_q.size() - fb != 0) begin err_cnt++; $display("FAIL drop_frame_count: got %0d expected 0", fd_cyc_q.size() - fb); end
    cmp_cnt++; if (adc_mux !== 3'd3) begin err_cnt++; $display("FAIL drop_idle_mux_hold: got %0d expected 3", adc_mux); end
  endtask

  task automatic test_reset_mid();
    int k0, sb;
    do_reset();
    sb = st_cyc_q.size();
    adc_mode = 1; chan_mask = 6'b001000; enable = 1'b1; k0 = cyc;
    wait_cyc(k0 + 2);
    cmp_cnt++; if (adc_mux !== 3'd3) begin err_cnt++; $display("FAIL rstmid_select_mux: got %0d expected 3", adc_mux); end
    reset = 1'b1;
    wait_cyc(k0 + 3);
    cmp_cnt++; if (adc_mux !== 3'd0) begin err_cnt++; $display("FAIL rstmid_adc_mux: got %0d expected 0", adc_mux); end
    cmp_cnt++; if (adc_start !== 1'b0) begin err_cnt++; $display("FAIL rstmid_adc_start: got %b expected 0", adc_start); end
    cmp_cnt++; if (wr_len !== 1'b0) begin err_cnt++; $display("FAIL rstmid_wr_len: got %b expected 0", wr_len); end
    cmp_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL rstmid_frame_done: got %b expected 0", frame_done); end
    reset = 1'b0; chan_mask = 6'd0; enable = 1'b1;
    wait_cyc(k0 + 45);
    cmp_cnt++; if (st_cyc_q.size() - sb != 0) begin err_cnt++; $display("FAIL rstmid_no_start: got %0d starts expected 0", st_cyc_q.size() - sb); end
    cmp_cnt++; if (adc_mux !== 3'd0) begin err_cnt++; $display("FAIL rstmid_mask0_mux: got %0d expected 0", adc_mux); end
    enable = 1'b0;
  endtask

`ifdef ADC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int k0, wb, a_c;
    logic [2:0] a_ch;
    logic [2:0] exp_ch [3];
    exp_ch = '{3'd0, 3'd1, 3'd3};
    do_reset();
    wb = wr_cyc_q.size();
    adc_mode = 3; chan_mask = 6'h3F; enable = 1'b1; k0 = cyc;
    wait_cyc(k0 + 33);
    cmp_cnt++; if (seq_err !== 1'b0) begin err_cnt++; $display("FAIL to_before: got %b expected 0", seq_err); end
    wait_cyc(k0 + 34);
    cmp_cnt++; if (seq_err !== 1'b1) begin err_cnt++; $display("FAIL to_set: got %b expected 1", seq_err); end
    wait_cyc(k0 + 44);
    cmp_cnt++; if (wr_cyc_q.size() - wb != 3) begin err_cnt++; $display("FAIL to_write_count: got %0d expected 3", wr_cyc_q.size() - wb); end
    for (int n = 0; n < 3; n++) begin
      a_ch = (wr_cyc_q.size() > wb + n) ? wr_chan_q[wb + n] : 3'd7;
      cmp_cnt++; if (a_ch !== exp_ch[n]) begin err_cnt++; $display("FAIL to_write%0d_chan: got %0d expected %0d", n, a_ch, exp_ch[n]); end
    end
    a_c = (wr_cyc_q.size() > wb + 2) ? wr_cyc_q[wb + 2] : -1;
    cmp_cnt++; if (a_c != k0 + 43) begin err_cnt++; $display("FAIL to_ch3_write_cycle: got %0d expected 43", a_c - k0); end
    cmp_cnt++; if (seq_err !== 1'b1) begin err_cnt++; $display("FAIL to_sticky: got %b expected 1", seq_err); end
    err_clr = 1'b1;
    wait_cyc(k0 + 45);
    err_clr = 1'b0;
    cmp_cnt++; if (seq_err !== 1'b0) begin err_cnt++; $display("FAIL to_clear: got %b expected 0", seq_err); end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; chan_mask = 6'd0; err_clr = 1'b0;
    test_reset();
    test_full_round();
    test_sparse();
    test_early_done();
    test_enable_drop();
    test_reset_mid();
`ifdef ADC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
